// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares a single-port memory between instruction fetch
// and data load/store. Data has priority; a streak counter bounds how many
// consecutive data grants may pass a waiting fetch. Each access takes
// MEM_LAT enabled cycles followed by a one-cycle ready pulse.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int BEAT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STREAK_W = $clog2(STARVE_MAX + 1);
  localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(MEM_LAT - 1);
  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_reg;
  logic [BEAT_W-1:0]   beat_reg;
  logic [STREAK_W-1:0] streak_reg;
  logic                grant_dm_reg;
  logic                mem_en_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic [DATA_W-1:0]   if_rdata_reg;
  logic [DATA_W-1:0]   dm_rdata_reg;
  logic                if_ready_reg;
  logic                dm_ready_reg;

  logic dm_req;
  logic pick_dm;

  // Data wins unless the fetch has already been passed over STARVE_MAX times.
  assign dm_req  = dm_read | dm_write;
  assign pick_dm = dm_req & ~(if_req & (streak_reg == STREAK_LIM));

  // Sequencer: grant in IDLE, hold the memory enabled for MEM_LAT beats, then pulse ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      beat_reg      <= '0;
      streak_reg    <= '0;
      grant_dm_reg  <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
      if_ready_reg  <= 1'b0;
      dm_ready_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if_ready_reg <= 1'b0;
          dm_ready_reg <= 1'b0;
          if (dm_req || if_req) begin
            grant_dm_reg  <= pick_dm;
            mem_en_reg    <= 1'b1;
            beat_reg      <= '0;
            mem_wdata_reg <= dm_wdata;
            state_reg     <= ACCESS;
            if (pick_dm) begin
              mem_addr_reg <= dm_addr;
              // A simultaneous read and write is handled as a store.
              mem_we_reg   <= dm_write;
              if (if_req) begin
                if (streak_reg != STREAK_LIM) begin
                  streak_reg <= streak_reg + STREAK_W'(1);
                end
              end else begin
                streak_reg <= '0;
              end
            end else begin
              mem_addr_reg <= if_addr;
              mem_we_reg   <= 1'b0;
              streak_reg   <= '0;
            end
          end else begin
            mem_en_reg <= 1'b0;
          end
        end
        ACCESS: begin
          if (beat_reg == LAST_BEAT) begin
            if (!mem_we_reg) begin
              if (grant_dm_reg) begin
                dm_rdata_reg <= mem_rdata;
              end else begin
                if_rdata_reg <= mem_rdata;
              end
            end
            if (grant_dm_reg) begin
              dm_ready_reg <= 1'b1;
            end else begin
              if_ready_reg <= 1'b1;
            end
            mem_en_reg <= 1'b0;
            mem_we_reg <= 1'b0;
            state_reg  <= RESP;
          end else begin
            beat_reg <= beat_reg + BEAT_W'(1);
          end
        end
        RESP: begin
          // No grant here, so a request still held through its ready is not served twice.
          if_ready_reg <= 1'b0;
          dm_ready_reg <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign if_rdata  = if_rdata_reg;
  assign dm_rdata  = dm_rdata_reg;
  assign if_ready  = if_ready_reg;
  assign dm_ready  = dm_ready_reg;

  // Stalls depend only on the requests and this cycle's ready pulse.
  assign stall_if  = if_req & ~if_ready_reg;
  assign stall_mem = dm_req & ~dm_ready_reg;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized scoreboard bench for unified_mem_arbiter. The driver keeps a
// transaction-level model (next free cycle, starvation streak, grant rules)
// and pushes expected ready cycles/data; a monitor checks every cycle.
module tb_unified_mem_arbiter;
  localparam int L    = 2;
  localparam int SM   = 2;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_read = 1'b0;
  logic        dm_write = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data is only valid in the last enabled beat of an access.
  int en_run = 0;
  always @(posedge clk) en_run <= mem_en ? en_run + 1 : 0;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h8C010004;
  endfunction

  assign mem_rdata = (mem_en && en_run == L - 1) ? rd_fn(mem_addr) : ~rd_fn(mem_addr);

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t        if_q[$];
  exp_t        dm_q[$];
  int          acc_start = 1;
  int          acc_end = 0;
  bit          acc_we = 1'b0;
  logic [31:0] acc_addr = '0;
  logic [31:0] acc_wdata = '0;
  int          zero_at = -1;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  // Monitor: samples on the falling edge, pops expectations when a ready is due.
  initial begin
    logic [31:0] m_if;
    logic [31:0] m_dm;
    exp_t        e;
    bit          exp_if;
    bit          exp_dm;
    bit          exp_en;
    int          c;
    m_if = '0;
    m_dm = '0;
    forever begin
      @(negedge clk);
      c = cyc;
      if (c == zero_at) begin
        m_if = '0;
        m_dm = '0;
      end
      exp_if = (if_q.size() > 0) && (if_q[0].cyc == c);
      exp_dm = (dm_q.size() > 0) && (dm_q[0].cyc == c);
      chk("if_ready", 64'(if_ready), 64'(exp_if));
      chk("dm_ready", 64'(dm_ready), 64'(exp_dm));
      if (exp_if) begin
        e = if_q.pop_front();
        if (e.rd) m_if = e.data;
        $display("[TB] cyc=%0d if_ready data=%h exp=%h", c, if_rdata, m_if);
      end
      if (exp_dm) begin
        e = dm_q.pop_front();
        if (e.rd) m_dm = e.data;
        $display("[TB] cyc=%0d dm_ready %s data=%h exp=%h", c, e.rd ? "load" : "store", dm_rdata, m_dm);
      end
      chk("if_rdata", 64'(if_rdata), 64'(m_if));
      chk("dm_rdata", 64'(dm_rdata), 64'(m_dm));
      chk("stall_if", 64'(stall_if), 64'(if_req & ~exp_if));
      chk("stall_mem", 64'(stall_mem), 64'((dm_read | dm_write) & ~exp_dm));
      exp_en = (c >= acc_start) && (c <= acc_end);
      chk("mem_en", 64'(mem_en), 64'(exp_en));
      chk("mem_we", 64'(mem_we), 64'(exp_en & acc_we));
      if (exp_en) begin
        chk("mem_addr", 64'(mem_addr), 64'(acc_addr));
        if (acc_we) chk("mem_wdata", 64'(mem_wdata), 64'(acc_wdata));
      end
    end
  end

  // Driver plus reference model: requests are held until the model's ready cycle.
  initial begin
    bit          if_act, if_gnt, dm_act, dm_gnt, dm_rd_b, dm_wr_b;
    bit          stress, quiet, rst_now, pick_dm;
    int          if_rdy, dm_rdy, free_at, streak, k;
    logic [31:0] if_a, dm_a, dm_wd;
    exp_t        e;
    if_act = 0; if_gnt = 0; dm_act = 0; dm_gnt = 0; dm_rd_b = 0; dm_wr_b = 0;
    if_rdy = 0; dm_rdy = 0; free_at = 0; streak = 0;
    if_a = '0; dm_a = '0; dm_wd = '0;
    reset = 1'b0;
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      k = cyc;
      stress = (k >= 1500) && (k < 2300);
      quiet  = (k >= NCYC - 80);
      if (if_act && if_gnt && k > if_rdy) if_act = 0;
      if (dm_act && dm_gnt && k > dm_rdy) dm_act = 0;
      if (!stress && if_act && if_gnt && k < if_rdy && $urandom_range(0, 31) == 0) if_act = 0;
      if (!stress && dm_act && dm_gnt && k < dm_rdy && $urandom_range(0, 31) == 0) dm_act = 0;
      if (k >= 4 && !if_act && !quiet && (stress || $urandom_range(0, 3) != 0)) begin
        if_act = 1; if_gnt = 0; if_a = $urandom & 32'hFFFF_FFFC;
      end
      if (k >= 4 && !dm_act && !quiet && (stress || $urandom_range(0, 1) == 0)) begin
        dm_act = 1; dm_gnt = 0; dm_a = $urandom & 32'hFFFF_FFFC; dm_wd = $urandom;
        case ($urandom_range(0, 3))
          0, 1:    begin dm_rd_b = 1; dm_wr_b = 0; end
          2:       begin dm_rd_b = 0; dm_wr_b = 1; end
          default: begin dm_rd_b = 1; dm_wr_b = 1; end
        endcase
      end
      if (!if_act) if_a = $urandom;
      if (!dm_act) begin dm_a = $urandom; dm_wd = $urandom; end
      rst_now = (k < 4) || (!quiet && !stress && $urandom_range(0, 199) == 0);
      reset    = !rst_now;
      if_req   = if_act;
      if_addr  = if_a;
      dm_read  = dm_act & dm_rd_b;
      dm_write = dm_act & dm_wr_b;
      dm_addr  = dm_a;
      dm_wdata = dm_wd;
      if (rst_now) begin
        // Abort: anything not yet completed is dropped and re-requested fresh.
        while (if_q.size() > 0 && if_q[$].cyc > k) void'(if_q.pop_back());
        while (dm_q.size() > 0 && dm_q[$].cyc > k) void'(dm_q.pop_back());
        if (acc_end > k) acc_end = k;
        if (if_gnt && if_rdy > k) if_gnt = 0;
        if (dm_gnt && dm_rdy > k) dm_gnt = 0;
        free_at = k + 1;
        streak  = 0;
        zero_at = k + 1;
        if (k >= 4) $display("[TB] cyc=%0d reset pulse", k);
      end else if (k >= free_at && (if_act || dm_act)) begin
        pick_dm   = dm_act && !(if_act && streak == SM);
        e.cyc     = k + L + 1;
        acc_start = k + 1;
        acc_end   = k + L;
        free_at   = k + L + 2;
        if (pick_dm) begin
          dm_gnt    = 1;
          dm_rdy    = k + L + 1;
          acc_we    = dm_wr_b;
          acc_addr  = dm_a;
          acc_wdata = dm_wd;
          e.rd      = !dm_wr_b;
          e.data    = rd_fn(dm_a);
          dm_q.push_back(e);
          streak = if_act ? ((streak + 1 > SM) ? SM : streak + 1) : 0;
        end else begin
          if_gnt    = 1;
          if_rdy    = k + L + 1;
          acc_we    = 0;
          acc_addr  = if_a;
          acc_wdata = dm_wd;
          e.rd      = 1;
          e.data    = rd_fn(if_a);
          if_q.push_back(e);
          streak = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("if_q_drained", 64'(if_q.size()), 64'd0);
    chk("dm_q_drained", 64'(dm_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
